// File: rtl/hazard_pkg.sv
// Shared types and stall lengths for the pipeline hazard controller.
// Holds the FSM state enum, the 2-bit stall count type and per-hazard stall lengths.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  typedef logic [1:0] stall_cnt_t;

  localparam stall_cnt_t STALL_BR_LOAD_EX  = 2'd2;
  localparam stall_cnt_t STALL_LOAD_USE    = 2'd1;
  localparam stall_cnt_t STALL_BR_ALU      = 2'd1;
  localparam stall_cnt_t STALL_BR_LOAD_MEM = 2'd1;
  localparam stall_cnt_t STALL_NONE        = 2'd0;

endpackage

// File: rtl/hazard_dep_check.sv
// Register dependency check between ID and the EX/MEM destinations.
// Ports: ID sources, EX/MEM destination info in; required stall count n out.
module hazard_dep_check
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              uses_rt,
  input  logic              branch,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  output stall_cnt_t        n
);

  logic m_ex;
  logic m_mem;

  // $0 is hardwired, so a write to it never creates a dependency.
  assign m_ex  = (ex_rd != '0) &&
                 ((ex_rd == rs) || (uses_rt && (ex_rd == rt)));
  assign m_mem = (mem_rd != '0) &&
                 ((mem_rd == rs) || (uses_rt && (mem_rd == rt)));

  // Ordered: a branch on a fresh load needs the longest wait.
  always_comb begin
    n = STALL_NONE;
    if (branch && ex_mem_read && m_ex)
      n = STALL_BR_LOAD_EX;
    else if (ex_mem_read && m_ex)
      n = STALL_LOAD_USE;
    else if (branch && ex_reg_write && m_ex)
      n = STALL_BR_ALU;
    else if (branch && mem_mem_read && m_mem)
      n = STALL_BR_LOAD_MEM;
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage pipeline (load-use, branch-in-ID,
// taken branch/jump, data-memory wait). Outputs: pc_write, if_id_write,
// if_id_flush, id_ex_bubble, pipe_freeze. HAZARD_PERF_EN adds counters.
module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] IF_ID_Rs,
  input  logic [REG_AW-1:0] IF_ID_Rt,
  input  logic              IF_ID_UsesRt,
  input  logic              ID_Branch,
  input  logic              ID_Jump,
  input  logic              branch_taken,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_RegWrite,
  input  logic [REG_AW-1:0] ID_EX_Rd,
  input  logic              EX_MEM_MemRead,
  input  logic [REG_AW-1:0] EX_MEM_Rd,
  input  logic              mem_stall_i,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              pipe_freeze
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic [CNT_W-1:0]  flush_count_o
`endif
);

  state_t     state_q, state_d;
  stall_cnt_t cnt_q, cnt_d;
  stall_cnt_t n;
  stall_cnt_t n_m1;

  hazard_dep_check #(
    .REG_AW (REG_AW)
  ) u_dep (
    .rs           (IF_ID_Rs),
    .rt           (IF_ID_Rt),
    .uses_rt      (IF_ID_UsesRt),
    .branch       (ID_Branch),
    .ex_mem_read  (ID_EX_MemRead),
    .ex_reg_write (ID_EX_RegWrite),
    .ex_rd        (ID_EX_Rd),
    .mem_mem_read (EX_MEM_MemRead),
    .mem_rd       (EX_MEM_Rd),
    .n            (n)
  );

  assign n_m1 = n - 2'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (rst_i) begin
      id_ex_bubble = 1'b1;
    end else if (mem_stall_i) begin
      // Whole pipe waits on memory; stall sequencing is paused.
      pipe_freeze = 1'b1;
    end else if (state_q == STALL) begin
      id_ex_bubble = 1'b1;
      cnt_d        = cnt_q - 2'd1;
      if (cnt_q == 2'd1)
        state_d = RUN;
    end else if (n != STALL_NONE) begin
      id_ex_bubble = 1'b1;
      cnt_d        = n_m1;
      state_d      = (n_m1 != 2'd0) ? STALL : RUN;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = ID_Jump || (ID_Branch && branch_taken);
    end
  end

`ifdef HAZARD_PERF_EN
  // Bubble outside reset marks exactly the stall cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if (id_ex_bubble && (stall_cycles_o != '1))
        stall_cycles_o <= stall_cycles_o + 1'b1;
      if (if_id_flush && (flush_count_o != '1))
        flush_count_o <= flush_count_o + 1'b1;
    end
  end
`endif

endmodule
